// File: rtl/lc3_control.sv
// lc3_control: multi-cycle control FSM for the LC-3 datapath.
// Sequences fetch / decode / execute and drives every bus enable, register
// load, mux select and write enable. Memory is a request/ready handshake
// (memEN/memWE held until memRdy); an optional wait limit flags memErr.
// Ports:
//   clk, rst (sync, active low)      clock and reset
//   IR, N, Z, P                      instruction and condition flags
//   memRdy                           memory access complete this cycle
//   enaALU/enaMARM/enaPC/enaMDR      bus drivers (never more than one)
//   ldPC/ldIR/ldMAR/ldMDR            register loads
//   selMDR, selPC, selEAB1/2, selMARM datapath selects
//   memEN, memWE                     memory request / write
//   flagWE, regWE                    flag and register-file writes
//   DR, SR1, SR2, ALUctrl            register addresses and ALU op
//   halted, memErr                   HALT state, sticky wait-limit error
module lc3_control #(
  parameter int MAX_WAIT     = 0,
  parameter bit HALT_ON_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        memRdy,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        memEN,
  output logic        memWE,
  output logic        flagWE,
  output logic        regWE,
  output logic [1:0]  selPC,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        selMARM,
  output logic [2:0]  DR,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [1:0]  ALUctrl,
  output logic        halted,
  output logic        memErr
);

  typedef enum logic [4:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC, S_BR0, S_JMP0,
    S_JSR0, S_JSR1, S_LEA0, S_ADDR, S_MRD, S_IND, S_WB, S_SDAT, S_MWR,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2,
                         OP_ST  = 4'h3, OP_JSR = 4'h4, OP_AND = 4'h5,
                         OP_LDR = 4'h6, OP_STR = 4'h7, OP_NOT = 4'h9,
                         OP_LDI = 4'hA, OP_JMP = 4'hC, OP_LEA = 4'hE,
                         OP_TRP = 4'hF;

  // Wait count at which the last permitted no-ready cycle is reached.
  localparam logic [15:0] WAIT_LIM = (MAX_WAIT > 0) ? 16'(MAX_WAIT - 1) : 16'd0;

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic        ind_q, ind_d;   // LDI: pointer already fetched, next MRD is data
  logic [3:0]  op_s;
  logic        mem_state_s;
  logic        timeout_s;
  logic        br_taken_s;
  logic        unused_ok_s;

  assign op_s        = IR[15:12];
  assign mem_state_s = (state_q == S_FETCH1) || (state_q == S_MRD) || (state_q == S_MWR);
  assign timeout_s   = (MAX_WAIT > 0) && mem_state_s && !memRdy && (wait_q == WAIT_LIM);
  assign br_taken_s  = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
  assign unused_ok_s = ^IR[5:3];

  // State, wait counter, sticky error and LDI indirection flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH0;
      wait_q  <= 16'd0;
      err_q   <= 1'b0;
      ind_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ind_q   <= ind_d;
    end
  end

  // Next-state and control outputs; everything is forced low while in reset.
  always_comb begin
    state_d = state_q;
    wait_d  = 16'd0;
    err_d   = err_q;
    ind_d   = ind_q;
    enaALU  = 1'b0; enaMARM = 1'b0; enaPC  = 1'b0; enaMDR = 1'b0;
    ldPC    = 1'b0; ldIR    = 1'b0; ldMAR  = 1'b0; ldMDR  = 1'b0;
    selMDR  = 1'b0; memEN   = 1'b0; memWE  = 1'b0;
    flagWE  = 1'b0; regWE   = 1'b0;
    selPC   = 2'b00; selEAB1 = 1'b0; selEAB2 = 2'b00; selMARM = 1'b0;
    DR      = 3'd0; SR1 = 3'd0; SR2 = 3'd0; ALUctrl = 2'b00;
    halted  = 1'b0;
    memErr  = 1'b0;
    if (!rst) begin
      state_d = S_FETCH0;
      err_d   = 1'b0;
      ind_d   = 1'b0;
    end else begin
      memErr = err_q;
      case (state_q)
        S_FETCH0: begin
          enaPC = 1'b1; ldMAR = 1'b1; ldPC = 1'b1; selPC = 2'b00;
          state_d = S_FETCH1;
        end
        S_FETCH1: begin
          memEN = 1'b1;
          if (memRdy) begin
            selMDR = 1'b1; ldMDR = 1'b1; state_d = S_FETCH2;
          end else begin
            state_d = S_FETCH1;
          end
        end
        S_FETCH2: begin
          enaMDR = 1'b1; ldIR = 1'b1; state_d = S_DECODE;
        end
        S_DECODE: begin
          ind_d = 1'b0;
          case (op_s)
            OP_ADD, OP_AND, OP_NOT:               state_d = S_EXEC;
            OP_BR:                                state_d = S_BR0;
            OP_JMP:                               state_d = S_JMP0;
            OP_JSR:                               state_d = S_JSR0;
            OP_LEA:                               state_d = S_LEA0;
            OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR: state_d = S_ADDR;
            OP_TRP:  state_d = HALT_ON_TRAP ? S_HALT : S_FETCH0;
            default:                              state_d = S_FETCH0;
          endcase
        end
        S_EXEC: begin
          enaALU = 1'b1; regWE = 1'b1; flagWE = 1'b1;
          DR = IR[11:9]; SR1 = IR[8:6]; SR2 = IR[2:0];
          case (op_s)
            OP_AND:  ALUctrl = 2'b01;
            OP_NOT:  ALUctrl = 2'b10;
            default: ALUctrl = 2'b00;
          endcase
          state_d = S_FETCH0;
        end
        S_BR0: begin
          if (br_taken_s) begin
            ldPC = 1'b1; selPC = 2'b01; selEAB1 = 1'b0; selEAB2 = 2'b10;
          end else begin
            ldPC = 1'b0;
          end
          state_d = S_FETCH0;
        end
        S_JMP0: begin
          enaALU = 1'b1; ALUctrl = 2'b11; SR1 = IR[8:6];
          ldPC = 1'b1; selPC = 2'b10;
          state_d = S_FETCH0;
        end
        S_JSR0: begin
          enaPC = 1'b1; regWE = 1'b1; DR = 3'd7;
          state_d = S_JSR1;
        end
        S_JSR1: begin
          ldPC = 1'b1;
          if (IR[11]) begin
            selPC = 2'b01; selEAB1 = 1'b0; selEAB2 = 2'b11;
          end else begin
            selPC = 2'b10; enaALU = 1'b1; ALUctrl = 2'b11; SR1 = IR[8:6];
          end
          state_d = S_FETCH0;
        end
        S_LEA0: begin
          enaMARM = 1'b1; selMARM = 1'b0; selEAB1 = 1'b0; selEAB2 = 2'b10;
          regWE = 1'b1; flagWE = 1'b1; DR = IR[11:9];
          state_d = S_FETCH0;
        end
        S_ADDR: begin
          enaMARM = 1'b1; ldMAR = 1'b1; selMARM = 1'b0;
          // Base+offset6 forms address off Ra; the rest are PC-relative.
          if ((op_s == OP_LDR) || (op_s == OP_STR)) begin
            selEAB1 = 1'b1; selEAB2 = 2'b01; SR1 = IR[8:6];
          end else begin
            selEAB1 = 1'b0; selEAB2 = 2'b10;
          end
          if ((op_s == OP_ST) || (op_s == OP_STR)) begin
            state_d = S_SDAT;
          end else begin
            state_d = S_MRD;
          end
        end
        S_MRD: begin
          memEN = 1'b1;
          if (memRdy) begin
            selMDR = 1'b1; ldMDR = 1'b1;
            state_d = ((op_s == OP_LDI) && !ind_q) ? S_IND : S_WB;
          end else begin
            state_d = S_MRD;
          end
        end
        S_IND: begin
          enaMDR = 1'b1; ldMAR = 1'b1; ind_d = 1'b1;
          state_d = S_MRD;
        end
        S_WB: begin
          enaMDR = 1'b1; regWE = 1'b1; flagWE = 1'b1; DR = IR[11:9];
          state_d = S_FETCH0;
        end
        S_SDAT: begin
          enaALU = 1'b1; ALUctrl = 2'b11; SR1 = IR[11:9];
          ldMDR = 1'b1; selMDR = 1'b0;
          state_d = S_MWR;
        end
        S_MWR: begin
          memEN = 1'b1; memWE = 1'b1;
          state_d = memRdy ? S_FETCH0 : S_MWR;
        end
        S_HALT: begin
          halted = 1'b1;
          state_d = S_HALT;
        end
        default: state_d = S_FETCH0;
      endcase
      // Wait limit overrides the handshake; count restarts on every state entry.
      if (timeout_s) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else if ((state_d == state_q) && mem_state_s && (wait_q != 16'hFFFF)) begin
        wait_d = wait_q + 16'd1;
      end else begin
        wait_d = 16'd0;
      end
    end
  end

endmodule
